// File: rtl/ysyx_23060096_mem_arbiter.sv
// Shares one memory port between the IFU and LSU. Out-of-range requests get a local error response.
// Define YSYX_23060096_ARB_ROUND_ROBIN_EN to break ties by round robin instead of fixed LSU priority.
module ysyx_23060096_mem_arbiter #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  MEM_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  MEM_SIZE = 32'h0800_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic                ifu_rsp_err,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic                lsu_rsp_err,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, BUSY_IFU, BUSY_LSU, ERR_IFU, ERR_LSU} state_t;

  state_t              state, state_nxt;
  logic                prio_lsu;
  logic                pick_lsu;
  logic                win_valid;
  logic                win_ok;
  logic                win_ready;
  logic                hs;
  logic                store_q;
  logic [ADDR_W-1:0]   win_addr;

  // Subtraction is only evaluated meaningfully once addr >= MEM_BASE, so no wrap.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_SIZE);
  endfunction

`ifdef YSYX_23060096_ARB_ROUND_ROBIN_EN
  logic last_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_lsu <= 1'b1;
    else if (hs) last_lsu <= pick_lsu;
  end

  assign prio_lsu = !last_lsu;
`else
  assign prio_lsu = 1'b1;
`endif

  assign pick_lsu  = lsu_req_valid && (!ifu_req_valid || prio_lsu);
  assign win_valid = ifu_req_valid || lsu_req_valid;
  assign win_addr  = pick_lsu ? lsu_addr : ifu_addr;
  assign win_ok    = in_range(win_addr);

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wen       = 1'b0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    win_ready     = 1'b0;
    hs            = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          if (win_ok) begin
            mem_req_valid = 1'b1;
            mem_addr      = win_addr;
            win_ready     = mem_req_ready;
            if (pick_lsu) begin
              mem_wen   = lsu_wen;
              mem_wdata = lsu_wdata;
              mem_wmask = lsu_wmask;
            end
          end else begin
            // Out-of-range requests are absorbed here and never reach memory.
            win_ready = 1'b1;
          end
          hs = win_ready;
          if (hs) begin
            if (win_ok) state_nxt = pick_lsu ? BUSY_LSU : BUSY_IFU;
            else        state_nxt = pick_lsu ? ERR_LSU  : ERR_IFU;
          end
        end
      end
      BUSY_IFU, BUSY_LSU: if (mem_rsp_valid) state_nxt = IDLE;
      ERR_IFU, ERR_LSU:   state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  assign ifu_req_ready = win_ready && !pick_lsu;
  assign lsu_req_ready = win_ready && pick_lsu;

  // The error pulse is launched at the handshake edge, so it is visible during ERR_x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      store_q       <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_err   <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      lsu_rdata     <= '0;
    end else begin
      state         <= state_nxt;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      if (state == IDLE && hs) begin
        store_q <= pick_lsu && lsu_wen;
        if (!win_ok) begin
          if (pick_lsu) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_err   <= 1'b1;
            lsu_rdata     <= '0;
          end else begin
            ifu_rsp_valid <= 1'b1;
            ifu_rsp_err   <= 1'b1;
            ifu_rdata     <= '0;
          end
        end
      end
      if (state == BUSY_IFU && mem_rsp_valid) begin
        ifu_rsp_valid <= 1'b1;
        ifu_rdata     <= mem_rdata;
      end
      if (state == BUSY_LSU && mem_rsp_valid) begin
        lsu_rsp_valid <= 1'b1;
        lsu_rdata     <= store_q ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_mem_arbiter.sv
// Directed bench for ysyx_23060096_mem_arbiter; the testbench acts as requesters and memory.
module tb_ysyx_23060096_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_23060096_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ifu_rv"}, 32'(ifu_rsp_valid), 32'd0);
    check({tag, "_lsu_rv"}, 32'(lsu_rsp_valid), 32'd0);
    check({tag, "_mrv"},    32'(mem_req_valid), 32'd0);
  endtask

  logic exp_lsu [4];

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    step(); step();
    check("rst_ifu_rdata", ifu_rdata, 32'h0);
    check("rst_lsu_rdata", lsu_rdata, 32'h0);
    check("rst_ifu_err",   32'(ifu_rsp_err), 32'd0);
    check_quiet("rst");
    rst_n = 1'b1;

    // Out-of-range fetches: below base and exactly one past the window.
    ifu_req_valid = 1; ifu_addr = 32'h7FFF_FFFC; mem_req_ready = 0;
    #1;
    check("err_lo_mrv",   32'(mem_req_valid), 32'd0);
    check("err_lo_ready", 32'(ifu_req_ready), 32'd1);
    check("err_lo_maddr", mem_addr, 32'h0);
    step(); ifu_req_valid = 0; #1;
    check("err_lo_rv",    32'(ifu_rsp_valid), 32'd1);
    check("err_lo_err",   32'(ifu_rsp_err), 32'd1);
    check("err_lo_rdata", ifu_rdata, 32'h0);
    check("err_lo_lsurv", 32'(lsu_rsp_valid), 32'd0);
    step();
    check("err_lo_pulse", 32'(ifu_rsp_valid), 32'd0);
    ifu_req_valid = 1; ifu_addr = 32'h8800_0000; #1;
    check("err_hi_mrv",   32'(mem_req_valid), 32'd0);
    check("err_hi_ready", 32'(ifu_req_ready), 32'd1);
    step(); ifu_req_valid = 0; #1;
    check("err_hi_rv",    32'(ifu_rsp_valid), 32'd1);
    check("err_hi_err",   32'(ifu_rsp_err), 32'd1);
    step();

    // Stray memory response while idle must be ignored.
    mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    step(); mem_rsp_valid = 0; #1;
    check_quiet("idle_rsp");

    // IFU only, k=2.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004; mem_req_ready = 1; #1;
    check("ifu_mrv",   32'(mem_req_valid), 32'd1);
    check("ifu_maddr", mem_addr, 32'h8000_0004);
    check("ifu_ready", 32'(ifu_req_ready), 32'd1);
    check("ifu_lready",32'(lsu_req_ready), 32'd0);
    check("ifu_mwen",  32'(mem_wen), 32'd0);
    check("ifu_mwmask",32'(mem_wmask), 32'd0);
    step(); ifu_req_valid = 0; #1;
    check("ifu_busy_mrv", 32'(mem_req_valid), 32'd0);
    check("ifu_busy_rv",  32'(ifu_rsp_valid), 32'd0);
    step(); mem_rsp_valid = 1; mem_rdata = 32'h00F0_0093;
    step(); mem_rsp_valid = 0; #1;
    check("ifu_rv",    32'(ifu_rsp_valid), 32'd1);
    check("ifu_rdata", ifu_rdata, 32'h00F0_0093);
    check("ifu_err",   32'(ifu_rsp_err), 32'd0);
    check("ifu_lsurv", 32'(lsu_rsp_valid), 32'd0);
    step();
    check("ifu_pulse", 32'(ifu_rsp_valid), 32'd0);

    // Tie: LSU load wins first, IFU next.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 0; #1;
    check("tie_lready", 32'(lsu_req_ready), 32'd1);
    check("tie_iready", 32'(ifu_req_ready), 32'd0);
    check("tie_maddr",  mem_addr, 32'h8000_0100);
    check("tie_mwen",   32'(mem_wen), 32'd0);
    step(); lsu_req_valid = 0; #1;
    check("tie_busy_iready", 32'(ifu_req_ready), 32'd0);
    check("tie_busy_mrv",    32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
    step(); mem_rsp_valid = 0; #1;
    check("tie_lsu_rv",    32'(lsu_rsp_valid), 32'd1);
    check("tie_lsu_rdata", lsu_rdata, 32'h1111_2222);
    check("tie_ifu_rv",    32'(ifu_rsp_valid), 32'd0);
    check("tie_ifu_maddr", mem_addr, 32'h8000_0000);
    check("tie_ifu_ready", 32'(ifu_req_ready), 32'd1);
    step(); ifu_req_valid = 0; #1;
    check("tie_gap_rv", 32'(ifu_rsp_valid), 32'd0);
    mem_rsp_valid = 1; mem_rdata = 32'h3333_4444;
    step(); mem_rsp_valid = 0; #1;
    check("tie_ifu_rv2",   32'(ifu_rsp_valid), 32'd1);
    check("tie_ifu_rdata", ifu_rdata, 32'h3333_4444);
    check("tie_lsu_rv2",   32'(lsu_rsp_valid), 32'd0);
    step();

    // LSU store with downstream backpressure for 3 cycles.
    lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_hold_mrv",   32'(mem_req_valid), 32'd1);
      check("st_hold_addr",  mem_addr, 32'h8000_0010);
      check("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_hold_wmask", 32'(mem_wmask), 32'h3);
      check("st_hold_wen",   32'(mem_wen), 32'd1);
      check("st_hold_ready", 32'(lsu_req_ready), 32'd0);
      step();
    end
    mem_req_ready = 1; #1;
    check("st_ready", 32'(lsu_req_ready), 32'd1);
    step(); lsu_req_valid = 0; lsu_wen = 0;
    mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    step(); mem_rsp_valid = 0; #1;
    check("st_rv",    32'(lsu_rsp_valid), 32'd1);
    check("st_rdata", lsu_rdata, 32'h0);
    check("st_err",   32'(lsu_rsp_err), 32'd0);
    step();

    // Reset while BUSY_IFU; the late memory response must be dropped.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    step(); ifu_req_valid = 0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
    step(); mem_rsp_valid = 0; #1;
    check_quiet("rst_mid");
    check("rst_mid_rdata", ifu_rdata, 32'h0);
    check("rst_mid_lrdata", lsu_rdata, 32'h0);
    step();
    check("rst_mid_rv2", 32'(ifu_rsp_valid), 32'd0);

    // Both requesters valid continuously for 4 transactions (fresh from reset).
`ifdef YSYX_23060096_ARB_ROUND_ROBIN_EN
    exp_lsu[0] = 0; exp_lsu[1] = 1; exp_lsu[2] = 0; exp_lsu[3] = 1;
`else
    exp_lsu[0] = 1; exp_lsu[1] = 1; exp_lsu[2] = 1; exp_lsu[3] = 1;
`endif
    ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_maddr", mem_addr, exp_lsu[i] ? 32'h8000_0200 : 32'h8000_0020);
      step();
      mem_rsp_valid = 1; mem_rdata = 32'hA0 + 32'(i);
      step(); mem_rsp_valid = 0; #1;
      check("cont_ifu_rv", 32'(ifu_rsp_valid), exp_lsu[i] ? 32'd0 : 32'd1);
      check("cont_lsu_rv", 32'(lsu_rsp_valid), exp_lsu[i] ? 32'd1 : 32'd0);
      check("cont_rdata", exp_lsu[i] ? lsu_rdata : ifu_rdata, 32'hA0 + 32'(i));
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
